// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Holds the architectural program counter, fetches the instruction at that
//   address from instruction memory and presents it to decode/execute. A new
//   PC from the BranchALU is committed on pcWriteEnable while an instruction
//   is held; a misaligned target halts the unit until reset.
//
// Ports
//   clock                in   system clock, rising edge
//   reset                in   asynchronous, active-high reset
//   programCounterInput  in   [31:0] next PC from the BranchALU
//   pcWriteEnable        in   retire held instruction and commit next PC
//   pcOfInstruction      out  [31:0] PC of the held instruction
//   fetchAddress         out  [31:0] memory request address (== PC)
//   fetchRequest         out  memory request valid
//   fetchReady           in   memory accepts the request this cycle
//   fetchDataValid       in   memory response valid
//   fetchData            in   [31:0] memory response word
//   instruction          out  [31:0] held instruction word
//   instructionValid     out  held instruction/PC valid for decode/execute
//   pcMisaligned         out  sticky: a committed target had bits [1:0] != 0
//   instructionsRetired  out  [31:0] count of successful commits (wraps)
module pc_fetch_unit #(
  // Must be word aligned (bits [1:0] == 0).
  parameter logic [31:0] RESET_VECTOR    = 32'h00000000,
  parameter logic [31:0] NOP_INSTRUCTION = 32'h00000013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] programCounterInput,
  input  logic        pcWriteEnable,
  output logic [31:0] pcOfInstruction,
  output logic [31:0] fetchAddress,
  output logic        fetchRequest,
  input  logic        fetchReady,
  input  logic        fetchDataValid,
  input  logic [31:0] fetchData,
  output logic [31:0] instruction,
  output logic        instructionValid,
  output logic        pcMisaligned,
  output logic [31:0] instructionsRetired
);

  typedef enum logic [1:0] {
    FETCH_REQ = 2'd0,
    WAIT_RESP = 2'd1,
    HOLD      = 2'd2,
    HALTED    = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] retired_count;
  logic        instr_valid_q;
  logic        misaligned_q;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= FETCH_REQ;
      pc_q          <= RESET_VECTOR;
      instr_q       <= NOP_INSTRUCTION;
      instr_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      retired_count <= 32'd0;
    end else begin
      case (state)
        FETCH_REQ: begin
          // Address and request stay stable until the memory accepts.
          if (fetchReady) begin
            state <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (fetchDataValid) begin
            instr_q       <= fetchData;
            instr_valid_q <= 1'b1;
            state         <= HOLD;
          end
        end
        HOLD: begin
          if (pcWriteEnable) begin
            instr_valid_q <= 1'b0;
            if (is_word_aligned(programCounterInput)) begin
              pc_q          <= programCounterInput;
              retired_count <= retired_count + 32'd1;
              state         <= FETCH_REQ;
            end else begin
              // PC and count are left at the faulting instruction.
              misaligned_q <= 1'b1;
              state        <= HALTED;
            end
          end
        end
        HALTED: begin
          // Terminal until reset.
        end
        default: begin
          state         <= HALTED;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // The request is gated by reset directly so it drops as soon as reset
  // rises, and is already asserted in the first cycle after release.
  assign fetchRequest        = (state == FETCH_REQ) && !reset;
  assign fetchAddress        = pc_q;
  assign pcOfInstruction     = pc_q;
  assign instruction         = instr_q;
  assign instructionValid    = instr_valid_q;
  assign pcMisaligned        = misaligned_q;
  assign instructionsRetired = retired_count;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clock;
  logic        reset;
  logic [31:0] programCounterInput;
  logic        pcWriteEnable;
  logic [31:0] pcOfInstruction;
  logic [31:0] fetchAddress;
  logic        fetchRequest;
  logic        fetchReady;
  logic        fetchDataValid;
  logic [31:0] fetchData;
  logic [31:0] instruction;
  logic        instructionValid;
  logic        pcMisaligned;
  logic [31:0] instructionsRetired;

  pc_fetch_unit #(
    .RESET_VECTOR   (32'h00000000),
    .NOP_INSTRUCTION(32'h00000013)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .programCounterInput(programCounterInput),
    .pcWriteEnable      (pcWriteEnable),
    .pcOfInstruction    (pcOfInstruction),
    .fetchAddress       (fetchAddress),
    .fetchRequest       (fetchRequest),
    .fetchReady         (fetchReady),
    .fetchDataValid     (fetchDataValid),
    .fetchData          (fetchData),
    .instruction        (instruction),
    .instructionValid   (instructionValid),
    .pcMisaligned       (pcMisaligned),
    .instructionsRetired(instructionsRetired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  // Transaction-level model of the fetch unit.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_count;
  logic        m_have;         // an instruction is held for execute
  logic        m_outstanding;  // a request has been accepted, no response yet
  logic        m_halted;
  logic        m_mis;
  int          resp_wait;
  int          resp_max;
  int          dut_accepts;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'd0) return 32'h00500093;
    return (a * 32'h9E3779B1) ^ 32'h00000013;
  endfunction

  task automatic model_reset();
    m_pc          = 32'h00000000;
    m_instr       = 32'h00000013;
    m_count       = 32'd0;
    m_have        = 1'b0;
    m_outstanding = 1'b0;
    m_halted      = 1'b0;
    m_mis         = 1'b0;
    resp_wait     = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  task automatic compare();
    logic exp_req;
    exp_req = !reset && !m_have && !m_outstanding && !m_halted;
    chk("fetchRequest", 32'(fetchRequest), 32'(exp_req));
    chk("fetchAddress", fetchAddress, m_pc);
    chk("pcOfInstruction", pcOfInstruction, m_pc);
    chk("instruction", instruction, m_instr);
    chk("instructionValid", 32'(instructionValid), 32'(m_have));
    chk("pcMisaligned", 32'(pcMisaligned), 32'(m_mis));
    chk("instructionsRetired", instructionsRetired, m_count);
  endtask

  // Advance the model by one clock edge using the inputs applied this cycle.
  task automatic step();
    if (reset) return;
    if (m_halted) return;
    if (m_have) begin
      if (pcWriteEnable) begin
        m_have = 1'b0;
        if (programCounterInput[1:0] == 2'b00) begin
          m_pc    = programCounterInput;
          m_count = m_count + 32'd1;
        end else begin
          m_mis    = 1'b1;
          m_halted = 1'b1;
        end
      end
    end else if (m_outstanding) begin
      if (fetchDataValid) begin
        m_instr       = fetchData;
        m_have        = 1'b1;
        m_outstanding = 1'b0;
      end
    end else if (fetchReady) begin
      m_outstanding = 1'b1;
      resp_wait     = $urandom_range(resp_max, 1);
    end
  endtask

  // spur: 0 = no stray response, 1 = random stray responses, 2 = always stray
  // (strays only while nothing is outstanding).
  task automatic do_cycle(input logic we, input logic [31:0] pci, input logic rdy, input int spur);
    pcWriteEnable       = we;
    programCounterInput = pci;
    fetchReady          = rdy;
    fetchDataValid      = 1'b0;
    fetchData           = $urandom;
    if (m_outstanding && !reset) begin
      resp_wait--;
      if (resp_wait <= 0) begin
        fetchDataValid = 1'b1;
        fetchData      = mem(m_pc);
      end
    end else if (spur == 2 || (spur == 1 && $urandom_range(3, 0) == 0)) begin
      fetchDataValid = 1'b1;
    end
    @(negedge clock);
    compare();
    if (fetchRequest && fetchReady) dut_accepts++;
    @(posedge clock);
    step();
    #1;
  endtask

  task automatic fetch_current();
    do_cycle(1'b0, 32'd0, 1'b1, 0);
    do_cycle(1'b0, 32'd0, 1'b1, 0);
  endtask

  initial begin
    logic [31:0] pci;
    logic        we;
    int          halted_cycles;

    resp_max = 1;
    dut_accepts = 0;
    reset = 1'b1;
    pcWriteEnable = 1'b0;
    programCounterInput = 32'd0;
    fetchReady = 1'b0;
    fetchDataValid = 1'b0;
    fetchData = 32'd0;
    model_reset();

    // Reset state
    @(posedge clock);
    #1;
    chk("rst_pc", pcOfInstruction, 32'h00000000);
    chk("rst_instr", instruction, 32'h00000013);
    chk("rst_valid", 32'(instructionValid), 32'd0);
    chk("rst_mis", 32'(pcMisaligned), 32'd0);
    chk("rst_count", instructionsRetired, 32'd0);
    chk("rst_req", 32'(fetchRequest), 32'd0);
    do_cycle(1'b0, 32'd0, 1'b1, 0);
    do_cycle(1'b0, 32'd0, 1'b1, 0);

    // First fetch after reset release
    reset = 1'b0;
    #1;
    chk("first_req", 32'(fetchRequest), 32'd1);
    chk("first_addr", fetchAddress, 32'h00000000);
    fetch_current();
    chk("first_valid", 32'(instructionValid), 32'd1);
    chk("first_instr", instruction, 32'h00500093);
    chk("first_pc", pcOfInstruction, 32'h00000000);

    // Sequential commits 4, 8, 12
    for (int k = 1; k <= 3; k++) begin
      do_cycle(1'b1, 32'(4 * k), 1'b1, 0);
      chk("seq_valid_drop", 32'(instructionValid), 32'd0);
      chk("seq_addr", fetchAddress, 32'(4 * k));
      fetch_current();
      chk("seq_instr", instruction, mem(32'(4 * k)));
    end
    chk("seq_count", instructionsRetired, 32'd3);

    // Backpressure: 5 refused cycles, then accepted
    do_cycle(1'b1, 32'd16, 1'b1, 0);
    dut_accepts = 0;
    for (int k = 0; k < 5; k++) begin
      do_cycle(1'b0, 32'd0, 1'b0, 0);
      chk("bp_req", 32'(fetchRequest), 32'd1);
      chk("bp_addr", fetchAddress, 32'd16);
    end
    do_cycle(1'b0, 32'd0, 1'b1, 0);
    do_cycle(1'b0, 32'd0, 1'b1, 0);
    do_cycle(1'b0, 32'd0, 1'b1, 0);
    chk("bp_accepts", 32'(dut_accepts), 32'd1);
    chk("bp_valid", 32'(instructionValid), 32'd1);

    // Asynchronous reset while waiting for a response
    do_cycle(1'b1, 32'd20, 1'b1, 0);
    do_cycle(1'b0, 32'd0, 1'b1, 0);
    fetchDataValid = 1'b0;
    fetchReady = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_pc", pcOfInstruction, 32'h00000000);
    chk("arst_req", 32'(fetchRequest), 32'd0);
    chk("arst_instr", instruction, 32'h00000013);
    chk("arst_count", instructionsRetired, 32'd0);
    model_reset();
    do_cycle(1'b0, 32'd0, 1'b0, 0);
    reset = 1'b0;
    do_cycle(1'b0, 32'd0, 1'b0, 2);
    chk("late_resp_valid", 32'(instructionValid), 32'd0);
    chk("late_resp_instr", instruction, 32'h00000013);
    chk("late_resp_req", 32'(fetchRequest), 32'd1);
    fetch_current();
    chk("restart_instr", instruction, 32'h00500093);

    // Counter wrap
    force dut.retired_count = 32'hFFFFFFFF;
    #1;
    release dut.retired_count;
    m_count = 32'hFFFFFFFF;
    chk("wrap_pre", instructionsRetired, 32'hFFFFFFFF);
    do_cycle(1'b1, 32'd4, 1'b1, 0);
    chk("wrap_post", instructionsRetired, 32'h00000000);
    fetch_current();

    // Misaligned commit halts the unit
    do_cycle(1'b1, 32'h00000102, 1'b1, 0);
    chk("mis_flag", 32'(pcMisaligned), 32'd1);
    chk("mis_pc", pcOfInstruction, 32'd4);
    chk("mis_count", instructionsRetired, 32'd0);
    chk("mis_valid", 32'(instructionValid), 32'd0);
    for (int k = 0; k < 6; k++) begin
      do_cycle(1'b1, 32'(8 * (k + 1)), 1'b1, 1);
      chk("halt_req", 32'(fetchRequest), 32'd0);
    end
    chk("halt_pc", pcOfInstruction, 32'd4);
    chk("halt_count", instructionsRetired, 32'd0);
    reset = 1'b1;
    #1;
    chk("halt_rst_mis", 32'(pcMisaligned), 32'd0);
    chk("halt_rst_pc", pcOfInstruction, 32'd0);
    model_reset();
    do_cycle(1'b0, 32'd0, 1'b0, 0);
    reset = 1'b0;

    // Randomized traffic
    resp_max = 3;
    halted_cycles = 0;
    for (int n = 0; n < 3000; n++) begin
      we = 1'($urandom_range(1, 0));
      if ($urandom_range(39, 0) == 0)
        pci = {$urandom, 2'b00} | 32'($urandom_range(3, 1));
      else if ($urandom_range(1, 0) == 0)
        pci = m_pc + 32'd4;
      else
        pci = {$urandom, 2'b00};
      do_cycle(we, pci, 1'($urandom_range(1, 0)), 1);
      if (m_halted) halted_cycles++;
      if (halted_cycles > 3) begin
        halted_cycles = 0;
        reset = 1'b1;
        model_reset();
        do_cycle(1'b0, 32'd0, 1'b1, 1);
        reset = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Holds the architectural program counter and fetches the instruction at that address over a valid/ready request and valid-only response interface.
- Presents the fetched instruction to decode and the current PC (pcOfInstruction) to the BranchALU.
- Commits the BranchALU's programCounterInput when control asserts pcWriteEnable.
- Halts on a misaligned target and counts retired instructions.

Parameters:
- RESET_VECTOR, 32'h00000000, PC value loaded on reset; bits [1:0] must be 0.
- NOP_INSTRUCTION, 32'h00000013, value of the instruction register after reset.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- programCounterInput  input  32  next PC from the BranchALU.
- pcWriteEnable  input  1  control strobe: retire the current instruction and commit programCounterInput.
- pcOfInstruction  output  32  PC of the instruction currently held.
- fetchAddress  output  32  instruction memory request address; always equals pcOfInstruction.
- fetchRequest  output  1  request valid.
- fetchReady  input  1  memory accepts the request this cycle.
- fetchDataValid  input  1  response word valid.
- fetchData  input  32  response word.
- instruction  output  32  held instruction word.
- instructionValid  output  1  instruction and pcOfInstruction are valid for decode/execute.
- pcMisaligned  output  1  sticky error flag: a committed target had bits [1:0] != 0.
- instructionsRetired  output  32  count of successful commits.

Behaviour:
- Reset (asynchronous, while reset=1) forces all of the following:
  - state = FETCH_REQ
  - pcOfInstruction = RESET_VECTOR
  - instruction = NOP_INSTRUCTION
  - instructionValid = 0, pcMisaligned = 0, instructionsRetired = 0
  - fetchRequest forced to 0 while reset is high
- State machine: FETCH_REQ, WAIT_RESP, HOLD, HALTED.
- FETCH_REQ:
  - fetchRequest = 1, fetchAddress = pcOfInstruction.
  - fetchReady = 1 → WAIT_RESP next cycle; otherwise stay, with address and request held stable.
- WAIT_RESP:
  - fetchRequest = 0.
  - fetchDataValid = 1 → instruction <= fetchData, then HOLD.
  - The response is legal no earlier than the cycle after acceptance; fetchDataValid in any other state is ignored.
- HOLD:
  - instructionValid = 1, driven as a registered function of state. It is 0 in every other state.
  - pcWriteEnable = 1 with programCounterInput[1:0] == 2'b00:
    - pcOfInstruction <= programCounterInput
    - instructionsRetired <= instructionsRetired + 1 (mod 2^32, wraps to 0)
    - go to FETCH_REQ
  - pcWriteEnable = 1 with programCounterInput[1:0] != 2'b00:
    - pcMisaligned <= 1; pcOfInstruction unchanged; counter unchanged
    - go to HALTED
  - pcWriteEnable = 0: remain in HOLD indefinitely; instruction and PC stable.
- HALTED:
  - Terminal until reset: no requests, instructionValid = 0, pcWriteEnable ignored.
  - pcMisaligned stays 1.
- pcWriteEnable outside HOLD is ignored (no PC change, no count).
- Latency:
  - Commit in cycle N → fetchRequest in N+1.
  - With fetchReady = 1 in N+1 and fetchDataValid = 1 in N+2, instructionValid = 1 in N+3.
  - Best case is 3 cycles per instruction.
- Reset mid-fetch:
  - An outstanding response arriving after reset release is ignored if the FSM is in FETCH_REQ.
  - The memory must be reset alongside this block.
- No speculative or next-line fetch; exactly one request outstanding at most.

Test Plan:
- Reset release with fetchReady = 1 and one-cycle response fetchData = 32'h00500093:
  - fetchAddress = 0 with fetchRequest = 1 in the first cycle.
  - instructionValid = 1 two cycles later, instruction = 32'h00500093, pcOfInstruction = 0.
- Sequential commits of programCounterInput = 4, 8, 12:
  - fetchAddress follows 4, 8, 12.
  - instructionsRetired = 3.
  - instructionValid deasserts the cycle after each commit.
- Memory backpressure (fetchReady = 0 for 5 cycles, then 1):
  - fetchRequest and fetchAddress stay stable for all 6 cycles.
  - Exactly one acceptance occurs.
- Commit programCounterInput = 32'h00000102:
  - pcMisaligned = 1, FSM in HALTED, pcOfInstruction unchanged, counter unchanged.
  - No further fetchRequest.
  - Subsequent pcWriteEnable pulses are ignored.
  - reset clears pcMisaligned and restarts at RESET_VECTOR.
- Asynchronous reset asserted mid-WAIT_RESP (between clock edges):
  - Outputs return to reset values immediately, before the next clock edge.
  - A late fetchDataValid after release is ignored.
  - Fetch restarts at RESET_VECTOR.
- Counter preloaded near wrap (force 32'hFFFFFFFF), then one valid commit → instructionsRetired = 0.
